// File: rtl/qu_pkg.sv
// Shared types for the physical-register busy table and its branch checkpoints.
package qu_pkg;
  localparam int PHY_RF_DEPTH = 128;
  localparam int NUM_CKPT     = 4;
  localparam int AW           = $clog2(PHY_RF_DEPTH);
  localparam int CW           = $clog2(NUM_CKPT);

  typedef logic [AW-1:0]           phy_addr_t;
  typedef logic [CW-1:0]           ckpt_id_t;
  typedef logic [PHY_RF_DEPTH-1:0] busy_vec_t;

  // Preg 0 is hardwired not-busy; AND with this everywhere a table is written.
  localparam busy_vec_t PREG0_OFF = ~busy_vec_t'(1);

  function automatic busy_vec_t onehot(input phy_addr_t a);
    busy_vec_t v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/busy_ckpt_bank.sv
// Branch checkpoint storage: per-slot snapshots of the busy table that keep
// absorbing writeback clears so a restore never resurrects a completed preg.
module busy_ckpt_bank
  import qu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      save_en,
  input  ckpt_id_t  save_id,
  input  busy_vec_t save_vec,
  input  busy_vec_t clr_mask,
  input  ckpt_id_t  restore_id,
  output busy_vec_t restore_vec
);

  busy_vec_t snap [NUM_CKPT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CKPT; k++) snap[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CKPT; k++) begin
        if (save_en && save_id == ckpt_id_t'(k))
          snap[k] <= save_vec & PREG0_OFF;
        else
          snap[k] <= snap[k] & ~clr_mask & PREG0_OFF;
      end
    end
  end

  assign restore_vec = snap[restore_id];

endmodule

// File: rtl/busy_table_ckpt.sv
// Multi-ported physical-register busy table: rename sets, writeback clears,
// issue reads, and mispredict recovery restores from a branch checkpoint.
module busy_table_ckpt
  import qu_pkg::*;
#(
  parameter int NUM_RD    = 4,
  parameter int NUM_SET   = 2,
  parameter int NUM_CLR   = 2,
  parameter bit RD_BYPASS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic [NUM_SET-1:0]   set_en,
  input  logic [NUM_SET*AW-1:0] set_addr,
  input  logic [NUM_CLR-1:0]   clr_en,
  input  logic [NUM_CLR*AW-1:0] clr_addr,
  input  logic                 ckpt_save,
  input  logic [CW-1:0]        ckpt_save_id,
  input  logic                 ckpt_restore,
  input  logic [CW-1:0]        ckpt_restore_id,
  output logic [AW:0]          busy_count
);

  busy_vec_t live;
  busy_vec_t set_mask;
  busy_vec_t clr_mask;
  busy_vec_t upd_live;
  busy_vec_t next_live;
  busy_vec_t restore_vec;
  logic      save_en;

  function automatic logic [AW:0] popcount(input busy_vec_t v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < PHY_RF_DEPTH; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  // Stage p0: port decode and next-state selection
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_SET; i++)
      if (set_en[i]) set_mask = set_mask | onehot(set_addr[i*AW +: AW]);
    for (int i = 0; i < NUM_CLR; i++)
      if (clr_en[i]) clr_mask = clr_mask | onehot(clr_addr[i*AW +: AW]);
    set_mask = set_mask & PREG0_OFF;
    clr_mask = clr_mask & PREG0_OFF;
    // Sets applied after clears so a reallocated preg stays busy.
    upd_live = ((live & ~clr_mask) | set_mask) & PREG0_OFF;
    // Restore squashes the renaming group, so its sets are discarded.
    next_live = ckpt_restore ? (restore_vec & ~clr_mask & PREG0_OFF) : upd_live;
  end

  assign save_en = ckpt_save & ~ckpt_restore;

  busy_ckpt_bank u_bank (
    .clk        (clk),
    .rst        (rst),
    .save_en    (save_en),
    .save_id    (ckpt_save_id),
    .save_vec   (upd_live),
    .clr_mask   (clr_mask),
    .restore_id (ckpt_restore_id),
    .restore_vec(restore_vec)
  );

  // Stage p1: live table and its population count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live       <= '0;
      busy_count <= '0;
    end else begin
      live       <= next_live;
      busy_count <= popcount(next_live);
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy[i] = live[rd_addr[i*AW +: AW]] &
                   ~(RD_BYPASS & clr_mask[rd_addr[i*AW +: AW]]);
    end
  end

endmodule

// File: tb/tb_busy_table_ckpt.sv
// Scoreboard bench for busy_table_ckpt: directed scenarios plus a short
// randomized run against a behavioural model.
module tb_busy_table_ckpt;
  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] rd_addr;
  logic [3:0]  rd_busy;
  logic [1:0]  set_en;
  logic [13:0] set_addr;
  logic [1:0]  clr_en;
  logic [13:0] clr_addr;
  logic        ckpt_save;
  logic [1:0]  ckpt_save_id;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;
  logic [7:0]  busy_count;

  busy_table_ckpt dut (
    .clk            (clk),
    .rst            (rst),
    .rd_addr        (rd_addr),
    .rd_busy        (rd_busy),
    .set_en         (set_en),
    .set_addr       (set_addr),
    .clr_en         (clr_en),
    .clr_addr       (clr_addr),
    .ckpt_save      (ckpt_save),
    .ckpt_save_id   (ckpt_save_id),
    .ckpt_restore   (ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id),
    .busy_count     (busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] rd;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation tagged for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_chk++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
      end else if (rd_busy !== e.rd || busy_count !== e.cnt) begin
        n_fail++;
        $display("FAIL %s: rd_busy=%b busy_count=%0d, required rd_busy=%b busy_count=%0d",
                 e.name, rd_busy, busy_count, e.rd, e.cnt);
      end
    end
  end

  task automatic expect_now(input string nm, input logic [3:0] r, input logic [7:0] c);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.rd   = r;
    e.cnt  = c;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_en = '0; set_addr = '0; clr_en = '0; clr_addr = '0;
    ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
  endtask

  task automatic set_rd(input logic [6:0] a0, input logic [6:0] a1,
                        input logic [6:0] a2, input logic [6:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  // Behavioural model for the random phase
  logic [127:0] live_m;
  logic [127:0] snap_m [4];

  initial begin
    logic [127:0] sm, cm, nl;
    logic [3:0]   r;
    logic [6:0]   a;
    rst = 1'b1;
    idle();
    set_rd(0, 0, 0, 0);
    tick(); tick();
    set_rd(0, 1, 64, 127);
    expect_now("reset_state", 4'b0000, 8'd0);
    tick();
    rst = 1'b0;
    for (int b = 0; b < 32; b++) begin
      set_rd(7'(4*b), 7'(4*b+1), 7'(4*b+2), 7'(4*b+3));
      expect_now("scan_idle", 4'b0000, 8'd0);
      tick();
    end

    // set p5,p9; then clear p5 with same-cycle bypass
    set_en = 2'b11; set_addr = {7'd9, 7'd5}; set_rd(5, 9, 0, 0);
    expect_now("set_not_bypassed", 4'b0000, 8'd0);
    tick(); idle();
    expect_now("set_visible", 4'b0011, 8'd2);
    tick();
    clr_en = 2'b01; clr_addr = {7'd0, 7'd5};
    expect_now("clr_bypass", 4'b0010, 8'd2);
    tick(); idle();
    expect_now("clr_count", 4'b0010, 8'd1);
    tick();

    // set and clear p7 together; set p0 ignored
    set_en = 2'b11; set_addr = {7'd0, 7'd7}; clr_en = 2'b01; clr_addr = {7'd0, 7'd7};
    set_rd(7, 0, 9, 0);
    expect_now("set_clr_cycle", 4'b0100, 8'd1);
    tick(); idle();
    expect_now("set_wins_p0_off", 4'b0101, 8'd2);
    tick();

    // duplicate addresses on both set ports, two clears
    set_en = 2'b11; set_addr = {7'd5, 7'd5}; clr_en = 2'b11; clr_addr = {7'd9, 7'd7};
    set_rd(7, 9, 5, 0);
    expect_now("dup_cycle", 4'b0000, 8'd2);
    tick(); idle();
    expect_now("dup_after", 4'b0100, 8'd1);
    tick();

    // checkpoint slot 2 with same-cycle set, later clear, then restore
    set_en = 2'b01; set_addr = {7'd0, 7'd12}; ckpt_save = 1'b1; ckpt_save_id = 2'd2;
    set_rd(5, 12, 20, 0);
    expect_now("save_cycle", 4'b0001, 8'd1);
    tick(); idle();
    set_en = 2'b01; set_addr = {7'd0, 7'd20};
    expect_now("after_save", 4'b0011, 8'd2);
    tick(); idle();
    clr_en = 2'b01; clr_addr = {7'd0, 7'd12};
    expect_now("clr_p12", 4'b0101, 8'd3);
    tick(); idle();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
    expect_now("restore_cycle", 4'b0101, 8'd2);
    tick(); idle();
    expect_now("restored_slot2", 4'b0001, 8'd1);
    tick();

    // restore and save to slot 1 together; restore with active set
    set_en = 2'b01; set_addr = {7'd0, 7'd40}; ckpt_save = 1'b1; ckpt_save_id = 2'd1;
    set_rd(40, 41, 42, 5);
    expect_now("save_slot1", 4'b1000, 8'd1);
    tick(); idle();
    set_en = 2'b01; set_addr = {7'd0, 7'd41};
    expect_now("set_p41", 4'b1001, 8'd2);
    tick(); idle();
    set_en = 2'b01; set_addr = {7'd0, 7'd42};
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; ckpt_save = 1'b1; ckpt_save_id = 2'd1;
    expect_now("rs_cycle", 4'b1011, 8'd3);
    tick(); idle();
    expect_now("restore_wins", 4'b1001, 8'd2);
    tick();
    set_en = 2'b01; set_addr = {7'd0, 7'd41};
    expect_now("reset_p41", 4'b1001, 8'd2);
    tick(); idle();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; set_en = 2'b01; set_addr = {7'd0, 7'd30};
    set_rd(30, 41, 40, 5);
    expect_now("restore_set_cycle", 4'b1110, 8'd3);
    tick(); idle();
    expect_now("slot1_kept_set_drop", 4'b1100, 8'd2);
    tick();

    // restore with same-cycle clear
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; clr_en = 2'b01; clr_addr = {7'd0, 7'd40};
    set_rd(40, 5, 0, 0);
    expect_now("restore_clr_cycle", 4'b0010, 8'd2);
    tick(); idle();
    expect_now("restore_clr_after", 4'b0010, 8'd1);
    tick();

    // asynchronous reset mid-cycle, snapshots cleared too
    set_rd(5, 0, 0, 0);
    expect_now("async_rst", 4'b0000, 8'd0);
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1; set_rd(5, 40, 0, 0);
    expect_now("post_rst_cycle", 4'b0000, 8'd0);
    tick(); idle();
    expect_now("post_rst_snap", 4'b0000, 8'd0);
    tick();

    // randomized run against the model, small address range for collisions
    live_m = '0;
    for (int k = 0; k < 4; k++) snap_m[k] = '0;
    for (int it = 0; it < 400; it++) begin
      set_en   = 2'($urandom);
      set_addr = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
      clr_en   = 2'($urandom);
      clr_addr = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
      rd_addr  = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)),
                  7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
      ckpt_save       = ($urandom_range(0, 3) == 0);
      ckpt_save_id    = 2'($urandom);
      ckpt_restore    = ($urandom_range(0, 11) == 0);
      ckpt_restore_id = 2'($urandom);
      sm = '0; cm = '0;
      for (int p = 0; p < 2; p++) begin
        if (set_en[p]) begin a = set_addr[p*7 +: 7]; if (a != 0) sm[a] = 1'b1; end
        if (clr_en[p]) begin a = clr_addr[p*7 +: 7]; if (a != 0) cm[a] = 1'b1; end
      end
      for (int i = 0; i < 4; i++) begin
        a = rd_addr[i*7 +: 7];
        r[i] = live_m[a] && !cm[a];
      end
      expect_now("random", r, 8'($countones(live_m)));
      if (ckpt_restore) nl = snap_m[ckpt_restore_id] & ~cm;
      else              nl = (live_m & ~cm) | sm;
      nl[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (ckpt_save && !ckpt_restore && ckpt_save_id == 2'(k)) snap_m[k] = (live_m & ~cm) | sm;
        else snap_m[k] = snap_m[k] & ~cm;
        snap_m[k][0] = 1'b0;
      end
      live_m = nl;
      tick();
    end
    idle();

    tick(); tick();
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
